activation_pipe: RTL and testbench

ACTIVATION_PIPE -- requirements
Module: activation_pipe

---
 rtl/activation_pkg.sv | 14 +
 rtl/activation_lane.sv | 41 ++++
 rtl/activation_pipe.sv | 112 +++++++++++
 tb/tb_activation_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// Shared definitions for the activation pipeline: activation mode encoding
// and the default lane width.
package activation_pkg;

    localparam int ACT_DATA_W = 17;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_mode_e;

endpackage

// File: rtl/activation_lane.sv
// One combinational activation lane: identity, ReLU, leaky ReLU or clipped ReLU,
// plus a flag reporting that the lane exceeded the clip ceiling.
module activation_lane
    import activation_pkg::*;
#(
    parameter int DATA_W     = ACT_DATA_W,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [DATA_W-1:0] i_x,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_ceil,
    output logic [DATA_W-1:0] o_y,
    output logic              o_clipped
);

    act_mode_e                w_mode;
    logic signed [DATA_W-1:0] w_x;
    logic signed [DATA_W-1:0] w_ceil;
    logic signed [DATA_W-1:0] w_relu;
    logic signed [DATA_W-1:0] w_leaky;

    assign w_mode  = act_mode_e'(i_mode);
    assign w_x     = i_x;
    assign w_ceil  = i_ceil;
    assign w_relu  = w_x[DATA_W-1] ? '0 : w_x;
    // Arithmetic shift floors toward minus infinity, so -1 stays -1.
    assign w_leaky = w_x >>> LEAK_SHIFT;

    assign o_clipped = (w_mode == ACT_CLIP) && (w_x > w_ceil);

    always_comb begin
        o_y = w_x;
        case (w_mode)
            ACT_RELU:  o_y = w_relu;
            ACT_LEAKY: o_y = w_x[DATA_W-1] ? w_leaky : w_x;
            ACT_CLIP:  o_y = (w_relu > w_ceil) ? w_ceil : w_relu;
            default:   o_y = w_x;
        endcase
    end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage elastic activation pipeline over LANES signed lanes, with a
// saturating count of lanes clipped in clipped-ReLU mode.
module activation_pipe
    import activation_pkg::*;
#(
    parameter int DATA_W     = ACT_DATA_W,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [1:0]              in_mode,
    input  logic [DATA_W-1:0]       in_clip,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    clr_count,
    output logic [15:0]             clip_count
);

    function automatic logic [DATA_W-1:0] clip_ceiling(input logic signed [DATA_W-1:0] c);
        return c[DATA_W-1] ? '0 : c;
    endfunction

    function automatic logic [15:0] count_clipped(input logic [LANES-1:0] f);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + 16'(f[i]);
        return n;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [DATA_W-1:0]       w_ceil;
    logic [LANES*DATA_W-1:0] w_lane_y;
    logic [LANES-1:0]        w_lane_clip;
    logic                    w_s2_load;
    logic                    w_s1_load;
    logic                    w_accept;

    logic                    r_vld_p1;
    logic [LANES*DATA_W-1:0] r_data_p1;
    logic                    r_vld_p2;
    logic [LANES*DATA_W-1:0] r_data_p2;
    logic [15:0]             r_clip_count;

    assign w_ceil = clip_ceiling(in_clip);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        activation_lane #(
            .DATA_W     (DATA_W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .i_x       (in_data[g*DATA_W +: DATA_W]),
            .i_mode    (in_mode),
            .i_ceil    (w_ceil),
            .o_y       (w_lane_y[g*DATA_W +: DATA_W]),
            .o_clipped (w_lane_clip[g])
        );
    end

    // S1 may refill whenever it is empty or about to move into S2.
    assign w_s2_load = !r_vld_p2 || out_ready;
    assign w_s1_load = !r_vld_p1 || w_s2_load;
    assign in_ready  = w_s1_load;
    assign w_accept  = in_valid && in_ready;

    // Stage 1: computed lanes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_load) begin
            r_vld_p1 <= in_valid;
        end
        if (w_accept) begin
            r_data_p1 <= w_lane_y;
        end
    end

    // Stage 2: output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
        end else if (w_s2_load) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= r_data_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_count) begin
            r_clip_count <= '0;
        end else if (w_accept && (in_mode == ACT_CLIP)) begin
            r_clip_count <= sat_add16(r_clip_count, count_clipped(w_lane_clip));
        end
    end

    assign out_valid  = r_vld_p2;
    assign out_data   = r_data_p2;
    assign clip_count = r_clip_count;

endmodule

// File: tb/tb_activation_pipe.sv
// Directed bench for activation_pipe at DATA_W=17, LANES=4, LEAK_SHIFT=3.
module tb_activation_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [67:0] in_data;
    logic [1:0]  in_mode;
    logic [16:0] in_clip;
    logic        out_valid;
    logic        out_ready;
    logic [67:0] out_data;
    logic        clr_count;
    logic [15:0] clip_count;

    int checks;
    int failures;

    logic [67:0] beats [10];
    logic [67:0] prev_data;
    logic        stalled_prev;
    logic        drop_seen;
    int          sent;
    int          recv;

    activation_pipe #(
        .DATA_W     (17),
        .LANES      (4),
        .LEAK_SHIFT (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_clip    (in_clip),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .clr_count  (clr_count),
        .clip_count (clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation did not finish");
    end

    function automatic logic [67:0] pk(input int a, input int b, input int c, input int d);
        return {d[16:0], c[16:0], b[16:0], a[16:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_one(input string tag, input logic [67:0] d, input logic [1:0] m,
                            input logic [16:0] c, input logic [67:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_clip  = c;
        step();
        in_valid = 1'b0;
        in_mode  = ~m;
        in_clip  = 17'd0;
        chk({tag, "_s1only"}, 68'(out_valid), 68'(0));
        step();
        chk({tag, "_valid"}, 68'(out_valid), 68'(1));
        chk({tag, "_data"}, out_data, exp);
        step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        in_clip   = '0;
        out_ready = 1'b1;
        clr_count = 1'b0;
        step();
        step();
        chk("rst_out_valid", 68'(out_valid), 68'(0));
        chk("rst_out_data", out_data, 68'(0));
        chk("rst_clip_count", 68'(clip_count), 68'(0));
        rst_n = 1'b1;
        chk("rst_in_ready", 68'(in_ready), 68'(1));

        send_one("relu", pk(-5, 0, 7, -65536), 2'd1, 17'd0, pk(0, 0, 7, 0));
        send_one("leaky", pk(-1, -16, -17, 100), 2'd2, 17'd0, pk(-1, -2, -3, 100));
        send_one("ident", pk(-1, -16, -17, 100), 2'd0, 17'd0, pk(-1, -16, -17, 100));
        chk("count_after_modes012", 68'(clip_count), 68'(0));
        send_one("clip50", pk(60, 50, -3, 51), 2'd3, 17'd50, pk(50, 50, 0, 50));
        chk("count_clip50", 68'(clip_count), 68'(2));
        send_one("clipneg", pk(9, 0, 0, 0), 2'd3, 17'h1FFFC, pk(0, 0, 0, 0));
        chk("count_clipneg", 68'(clip_count), 68'(3));

        in_valid = 1'b0;
        in_mode  = 2'd3;
        in_data  = pk(5, 5, 5, 5);
        step();
        chk("count_no_accept", 68'(clip_count), 68'(3));

        for (int i = 0; i < 10; i++) beats[i] = pk(i, 100 + i, -i - 1, 3 * i);
        in_mode      = 2'd0;
        sent         = 0;
        recv         = 0;
        drop_seen    = 1'b0;
        stalled_prev = 1'b0;
        prev_data    = '0;
        for (int t = 0; t < 60 && recv < 10; t++) begin
            out_ready = !(t >= 3 && t <= 6);
            in_valid  = (sent < 10);
            in_data   = (sent < 10) ? beats[sent] : '0;
            #1;
            if (stalled_prev) chk("stall_hold", out_data, prev_data);
            if (in_valid && !in_ready && !drop_seen) begin
                drop_seen = 1'b1;
                chk("buffered_at_drop", 68'(sent - recv), 68'(2));
            end
            if (out_valid && out_ready) begin
                chk("stream_order", out_data, beats[recv]);
                recv++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_received", 68'(recv), 68'(10));
        chk("stream_backpressure", 68'(drop_seen), 68'(1));

        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        chk("clr_idle", 68'(clip_count), 68'(0));
        in_mode  = 2'd3;
        in_clip  = 17'd0;
        in_data  = pk(1, 1, 1, 1);
        in_valid = 1'b1;
        repeat (16383) step();
        in_data = pk(1, 1, 0, 0);
        step();
        in_valid = 1'b0;
        chk("count_fffe", 68'(clip_count), 68'(16'hFFFE));
        in_data  = pk(1, 1, 1, 1);
        in_valid = 1'b1;
        step();
        chk("count_sat", 68'(clip_count), 68'(16'hFFFF));
        step();
        chk("count_sat_hold", 68'(clip_count), 68'(16'hFFFF));
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        in_valid  = 1'b0;
        chk("clr_priority", 68'(clip_count), 68'(0));
        repeat (3) step();

        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("inflight_count", 68'(clip_count), 68'(8));
        chk("inflight_valid", 68'(out_valid), 68'(1));
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", 68'(out_valid), 68'(0));
        chk("midrst_out_data", out_data, 68'(0));
        chk("midrst_clip_count", 68'(clip_count), 68'(0));
        rst_n = 1'b1;
        chk("midrst_in_ready", 68'(in_ready), 68'(1));
        for (int k = 0; k < 4; k++) begin
            step();
            chk("no_stale_beat", 68'(out_valid), 68'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
